joypad_controller: RTL



---
 rtl/joypad_controller_if.sv | 26 ++
 rtl/joypad_controller.sv | 115 +++++++++++
 2 files changed

// File: rtl/joypad_controller_if.sv
// Purpose: peripheral bus bundle (addr/wdata/rdata/read_en/write_en) shared by the GB I/O blocks.
// Latency: none; plain wires between the CPU side and a peripheral.
// Backpressure: none; every access completes in the cycle it is presented.
interface Bus_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        read_en;
    logic        write_en;

    modport Peripheral_side (
        input  addr,
        input  wdata,
        input  read_en,
        input  write_en,
        output rdata
    );

    modport Host_side (
        output addr,
        output wdata,
        output read_en,
        output write_en,
        input  rdata
    );
endinterface

// File: rtl/joypad_controller.sv
// Purpose: P1/JOYP responder; syncs + debounces host buttons, muxes them by select bits, raises joypad IRQ.
// Latency: raw->debounced 2+DEBOUNCE_CYCLES cycles; bus read combinational; irq 1 cycle after P10-P13 falls.
// Backpressure: none; bus accesses are accepted every cycle.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   bus          peripheral bus (addr, wdata, read_en, write_en in; rdata out)
//   buttons_raw  async button levels, 1 = pressed: R,L,U,D,A,B,Select,Start (bit 0..7)
//   irq_joypad   one-cycle interrupt request pulse
module joypad_controller #(
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [15:0] JOYPAD_ADDR     = 16'hFF00
) (
    input  logic            clk,
    input  logic            reset,
    Bus_if.Peripheral_side  bus,
    input  logic [7:0]      buttons_raw,
    output logic            irq_joypad
);

    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [7:0] w_btn_db;
    logic [1:0] r_sel;
    logic [3:0] r_prev_p1;
    logic       r_irq;

    logic [3:0] w_dir_n;
    logic [3:0] w_act_n;
    logic [3:0] w_p1_low;
    logic       w_rd_hit;
    logic       w_wr_hit;
    logic       w_unused_wdata;

    // Two-flop synchroniser on every button line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= buttons_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign w_btn_db = r_sync2;
        end else begin : g_debounce
            localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [7:0]    r_db;
            logic [CW-1:0] r_cnt [8];

            // Counter tracks how long the synced level has disagreed with the
            // accepted level; it commits on the step that would reach the
            // threshold, so it never has to hold DEBOUNCE_CYCLES itself.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_db <= '0;
                    for (int i = 0; i < 8; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < 8; i++) begin
                        if (r_sync2[i] == r_db[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            r_db[i]  <= r_sync2[i];
                            r_cnt[i] <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                end
            end

            assign w_btn_db = r_db;
        end
    endgenerate

    // Active-low select: a 0 in sel[0] exposes directions, sel[1] actions.
    assign w_dir_n  = r_sel[0] ? 4'hF : ~w_btn_db[3:0];
    assign w_act_n  = r_sel[1] ? 4'hF : ~w_btn_db[7:4];
    assign w_p1_low = w_dir_n & w_act_n;

    assign w_rd_hit = bus.read_en  && (bus.addr == JOYPAD_ADDR);
    assign w_wr_hit = bus.write_en && (bus.addr == JOYPAD_ADDR);

    // Reads see the registered sel, so a same-cycle write is not yet visible.
    assign bus.rdata = w_rd_hit ? {2'b11, r_sel, w_p1_low} : 8'hFF;

    // Only the select bits of the write data are stored.
    assign w_unused_wdata = &{1'b0, bus.wdata[7:6], bus.wdata[3:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel     <= 2'b11;
            r_prev_p1 <= 4'hF;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr_hit) begin
                r_sel <= bus.wdata[5:4];
            end
            // Any line going 1->0 fires, whether from a press or a select write.
            r_prev_p1 <= w_p1_low;
            r_irq     <= |(r_prev_p1 & ~w_p1_low);
        end
    end

    assign irq_joypad = r_irq;

endmodule
